// File: rtl/localizer_sequencer.sv
// Collects one TDOA triple from three mic channels, drives localizer_2, waits for it
// to settle, then presents the latched position on a valid/ready port.
module localizer_sequencer #(
  parameter int unsigned TAU_W         = 34,
  parameter int unsigned POS_W         = 84,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned WINDOW        = 64,
  parameter int unsigned DROP_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        tau_valid_i,
  input  logic [TAU_W-1:0]  tau_in_0_i,
  input  logic [TAU_W-1:0]  tau_in_1_i,
  input  logic [TAU_W-1:0]  tau_in_2_i,
  output logic [TAU_W-1:0]  loc_tau1_o,
  output logic [TAU_W-1:0]  loc_tau2_o,
  output logic [TAU_W-1:0]  loc_tau3_o,
  input  logic [POS_W-1:0]  loc_posx_i,
  input  logic [POS_W-1:0]  loc_posy_i,
  output logic [POS_W-1:0]  pos_x_o,
  output logic [POS_W-1:0]  pos_y_o,
  output logic              pos_valid_o,
  input  logic              pos_ready_i,
  output logic              busy_o,
  output logic [DROP_W-1:0] drop_count_o
);

  localparam int unsigned WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SETTLE, S_OUT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cap_q, cap_d;
  logic [TAU_W-1:0]    stage_q [3];
  logic [TAU_W-1:0]    stage_d [3];
  logic [TAU_W-1:0]    ltau_q  [3];
  logic [TAU_W-1:0]    ltau_d  [3];
  logic [WIN_W-1:0]    win_q, win_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [POS_W-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic                pv_q, pv_d;
  logic                busy_q;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [TAU_W-1:0]    tau_in_c [3];
  logic [2:0]          take_c;
  logic                launch_c;

  assign tau_in_c[0] = tau_in_0_i;
  assign tau_in_c[1] = tau_in_1_i;
  assign tau_in_c[2] = tau_in_2_i;

  // Next-state and datapath: capture, window timeout, settle count, handshake
  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    win_d    = win_q;
    set_d    = set_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    pv_d     = pv_q;
    drop_d   = drop_q;
    launch_c = 1'b0;
    take_c   = 3'b000;
    for (int k = 0; k < 3; k++) begin
      stage_d[k] = stage_q[k];
      ltau_d[k]  = ltau_q[k];
    end

    if (state_q == S_IDLE)         take_c = tau_valid_i;
    else if (state_q == S_COLLECT) take_c = tau_valid_i & ~cap_q;
    for (int k = 0; k < 3; k++) begin
      if (take_c[k]) stage_d[k] = tau_in_c[k];
    end

    case (state_q)
      S_IDLE: begin
        if (|tau_valid_i) begin
          cap_d = tau_valid_i;
          win_d = '0;
          if (&tau_valid_i) launch_c = 1'b1;
          else              state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        cap_d = cap_q | take_c;
        win_d = WIN_W'(win_q + 1'b1);
        // completion takes priority over a timeout on the same edge
        if (&cap_d) begin
          launch_c = 1'b1;
        end else if (win_d == WIN_LAST) begin
          cap_d   = '0;
          state_d = S_IDLE;
          if (drop_q != '1) drop_d = DROP_W'(drop_q + 1'b1);
        end
      end
      S_SETTLE: begin
        if (set_q == SET_LAST) begin
          pos_x_d = loc_posx_i;
          pos_y_d = loc_posy_i;
          pv_d    = 1'b1;
          state_d = S_OUT;
        end else begin
          set_d = SET_W'(set_q + 1'b1);
        end
      end
      S_OUT: begin
        if (pv_q && pos_ready_i) begin
          pv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch_c) begin
      state_d = S_SETTLE;
      cap_d   = '0;
      set_d   = '0;
      for (int k = 0; k < 3; k++) ltau_d[k] = stage_d[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      win_q   <= '0;
      set_q   <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      pv_q    <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
      for (int k = 0; k < 3; k++) begin
        stage_q[k] <= '0;
        ltau_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      win_q   <= win_d;
      set_q   <= set_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      pv_q    <= pv_d;
      busy_q  <= (state_d != S_IDLE);
      drop_q  <= drop_d;
      for (int k = 0; k < 3; k++) begin
        stage_q[k] <= stage_d[k];
        ltau_q[k]  <= ltau_d[k];
      end
    end
  end

  assign loc_tau1_o   = ltau_q[0];
  assign loc_tau2_o   = ltau_q[1];
  assign loc_tau3_o   = ltau_q[2];
  assign pos_x_o      = pos_x_q;
  assign pos_y_o      = pos_y_q;
  assign pos_valid_o  = pv_q;
  assign busy_o       = busy_q;
  assign drop_count_o = drop_q;

endmodule
